rca_config_unit: RTL and testbench

RCA_CONFIG_UNIT -- requirements
Module: rca_config_unit

---
 rtl/rca_config_unit.sv | 158 +++++++++++++++
 tb/tb_rca_config_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_config_unit.sv
// Config sequencer for reconfigurable accelerators: drains in-flight use instructions, then
// writes one source/destination register-table entry. Define RCA_CFG_ERR_EN to enable cfg_err.
module rca_config_unit #(
  parameter int unsigned NUM_RCAS        = 3,
  parameter int unsigned NUM_READ_PORTS  = 5,
  parameter int unsigned NUM_WRITE_PORTS = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned RW = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1,
  localparam int unsigned PW = (NUM_READ_PORTS > 1) ? $clog2(NUM_READ_PORTS) : 1,
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [RW-1:0]                cfg_rca_sel,
  input  logic [PW-1:0]                cfg_port_sel,
  input  logic                         cfg_src_dest,
  input  logic [4:0]                   cfg_reg_addr,
  output logic                         cfg_done,
  output logic                         cfg_err,
  input  logic                         use_issue,
  input  logic [RW-1:0]                use_rca_sel,
  input  logic                         use_complete,
  input  logic [RW-1:0]                use_complete_rca_sel,
  output logic [NUM_RCAS-1:0]          use_stall,
  input  logic [RW-1:0]                rd_rca_sel,
  output logic [5*NUM_READ_PORTS-1:0]  rca_src_reg_addrs,
  output logic [5*NUM_WRITE_PORTS-1:0] rca_dest_reg_addrs,
  output logic [NUM_RCAS-1:0]          rca_configured
);

  typedef enum logic [1:0] {StIdle, StDrain, StWrite, StDone} state_e;

  state_e                     state_q;
  logic [RW-1:0]              rca_q;
  logic [PW-1:0]              port_q;
  logic                       src_dest_q;
  logic [4:0]                 addr_q;
  logic                       cfg_done_q;
  logic [4:0]                 src_q    [NUM_RCAS][NUM_READ_PORTS];
  logic [4:0]                 dst_q    [NUM_RCAS][NUM_WRITE_PORTS];
  logic [NUM_READ_PORTS-1:0]  src_wr_q [NUM_RCAS];
  logic [NUM_WRITE_PORTS-1:0] dst_wr_q [NUM_RCAS];
  logic [CW-1:0]              cnt_q    [NUM_RCAS];
  logic [CW-1:0]              cnt_d    [NUM_RCAS];
  logic                       drop;
  logic                       drain_ok;

  always_comb begin
    drop = (32'(rca_q) >= NUM_RCAS) ||
           (src_dest_q ? (32'(port_q) >= NUM_WRITE_PORTS) : (32'(port_q) >= NUM_READ_PORTS));
    drain_ok = 1'b1;
    for (int r = 0; r < NUM_RCAS; r++) begin
      if (rca_q == RW'(r) && cnt_q[r] != '0) drain_ok = 1'b0;
    end
  end

  // Issue and complete in the same cycle cancel, even when one alone would be ignored.
  always_comb begin
    for (int r = 0; r < NUM_RCAS; r++) begin
      logic inc, dec;
      inc      = use_issue && (use_rca_sel == RW'(r));
      dec      = use_complete && (use_complete_rca_sel == RW'(r));
      cnt_d[r] = cnt_q[r];
      if (inc && !dec && cnt_q[r] != CW'(MAX_OUTSTANDING)) cnt_d[r] = cnt_q[r] + 1'b1;
      else if (dec && !inc && cnt_q[r] != '0)              cnt_d[r] = cnt_q[r] - 1'b1;
    end
  end

  always_comb begin
    rca_src_reg_addrs  = '0;
    rca_dest_reg_addrs = '0;
    for (int r = 0; r < NUM_RCAS; r++) begin
      use_stall[r]      = (cnt_q[r] == CW'(MAX_OUTSTANDING)) ||
                          (state_q != StIdle && rca_q == RW'(r));
      rca_configured[r] = (&src_wr_q[r]) && (&dst_wr_q[r]);
      if (rd_rca_sel == RW'(r)) begin
        for (int p = 0; p < NUM_READ_PORTS; p++)  rca_src_reg_addrs[5*p +: 5]  = src_q[r][p];
        for (int p = 0; p < NUM_WRITE_PORTS; p++) rca_dest_reg_addrs[5*p +: 5] = dst_q[r][p];
      end
    end
  end

  assign cfg_ready = (state_q == StIdle);
  assign cfg_done  = cfg_done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rca_q      <= '0;
      port_q     <= '0;
      src_dest_q <= 1'b0;
      addr_q     <= '0;
      cfg_done_q <= 1'b0;
      for (int r = 0; r < NUM_RCAS; r++) begin
        cnt_q[r]    <= '0;
        src_wr_q[r] <= '0;
        dst_wr_q[r] <= '0;
        for (int p = 0; p < NUM_READ_PORTS; p++)  src_q[r][p] <= '0;
        for (int p = 0; p < NUM_WRITE_PORTS; p++) dst_q[r][p] <= '0;
      end
    end else begin
      cfg_done_q <= 1'b0;
      for (int r = 0; r < NUM_RCAS; r++) cnt_q[r] <= cnt_d[r];
      unique case (state_q)
        StIdle: begin
          if (cfg_valid) begin
            rca_q      <= cfg_rca_sel;
            port_q     <= cfg_port_sel;
            src_dest_q <= cfg_src_dest;
            addr_q     <= cfg_reg_addr;
            state_q    <= StDrain;
          end
        end
        StDrain: if (drain_ok) state_q <= StWrite;
        StWrite: begin
          state_q    <= StDone;
          cfg_done_q <= 1'b1;
          if (!drop) begin
            for (int r = 0; r < NUM_RCAS; r++) begin
              if (rca_q == RW'(r)) begin
                for (int p = 0; p < NUM_READ_PORTS; p++) begin
                  if (!src_dest_q && port_q == PW'(p)) begin
                    src_q[r][p]    <= addr_q;
                    src_wr_q[r][p] <= 1'b1;
                  end
                end
                for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                  if (src_dest_q && port_q == PW'(p)) begin
                    dst_q[r][p]    <= addr_q;
                    dst_wr_q[r][p] <= 1'b1;
                  end
                end
              end
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef RCA_CFG_ERR_EN
  logic cfg_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) cfg_err_q <= 1'b0;
    else        cfg_err_q <= (state_q == StWrite) && drop;
  end

  assign cfg_err = cfg_err_q;
`else
  assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_rca_config_unit.sv
// Scoreboard bench for rca_config_unit: expected config writes are queued at handshake and
// checked (latency, cfg_err, tables, rca_configured) when cfg_done pulses.
module tb_rca_config_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_rca_sel = '0;
  logic [2:0]  cfg_port_sel = '0;
  logic        cfg_src_dest = 1'b0;
  logic [4:0]  cfg_reg_addr = '0;
  logic        cfg_done, cfg_err;
  logic        use_issue = 1'b0;
  logic [1:0]  use_rca_sel = '0;
  logic        use_complete = 1'b0;
  logic [1:0]  use_complete_rca_sel = '0;
  logic [2:0]  use_stall;
  logic [1:0]  rd_rca_sel, rd_sel_main = '0, rd_sel_mon = '0;
  logic        mon_active = 1'b0;
  logic [24:0] rca_src_reg_addrs;
  logic [9:0]  rca_dest_reg_addrs;
  logic [2:0]  rca_configured;

  assign rd_rca_sel = mon_active ? rd_sel_mon : rd_sel_main;

  rca_config_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cfg_valid           (cfg_valid),
    .cfg_ready           (cfg_ready),
    .cfg_rca_sel         (cfg_rca_sel),
    .cfg_port_sel        (cfg_port_sel),
    .cfg_src_dest        (cfg_src_dest),
    .cfg_reg_addr        (cfg_reg_addr),
    .cfg_done            (cfg_done),
    .cfg_err             (cfg_err),
    .use_issue           (use_issue),
    .use_rca_sel         (use_rca_sel),
    .use_complete        (use_complete),
    .use_complete_rca_sel(use_complete_rca_sel),
    .use_stall           (use_stall),
    .rd_rca_sel          (rd_rca_sel),
    .rca_src_reg_addrs   (rca_src_reg_addrs),
    .rca_dest_reg_addrs  (rca_dest_reg_addrs),
    .rca_configured      (rca_configured)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int rca;
    int port;
    bit dst;
    int addr;
    int hs;
    int lat;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_src[4][5];
  int   m_dst[4][2];
  bit   m_srcw[3][5];
  bit   m_dstw[3][2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < 5; p++) m_src[r][p] = 0;
      for (int p = 0; p < 2; p++) m_dst[r][p] = 0;
    end
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 5; p++) m_srcw[r][p] = 1'b0;
      for (int p = 0; p < 2; p++) m_dstw[r][p] = 1'b0;
    end
  endtask

  function automatic logic [24:0] exp_src(input int r);
    logic [24:0] v = '0;
    for (int p = 0; p < 5; p++) v[5*p +: 5] = 5'(m_src[r][p]);
    return v;
  endfunction

  function automatic logic [9:0] exp_dst(input int r);
    logic [9:0] v = '0;
    for (int p = 0; p < 2; p++) v[5*p +: 5] = 5'(m_dst[r][p]);
    return v;
  endfunction

  function automatic logic [2:0] exp_cfgd();
    logic [2:0] v;
    for (int r = 0; r < 3; r++) begin
      v[r] = 1'b1;
      for (int p = 0; p < 5; p++) if (!m_srcw[r][p]) v[r] = 1'b0;
      for (int p = 0; p < 2; p++) if (!m_dstw[r][p]) v[r] = 1'b0;
    end
    return v;
  endfunction

  // Scoreboard consumer: one queued write per cfg_done pulse.
  always @(negedge clk) begin
    if (rst_n && cfg_done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        bit   drop, exp_err;
        e    = q.pop_front();
        drop = (e.rca >= 3) || (e.dst ? e.port >= 2 : e.port >= 5);
`ifdef RCA_CFG_ERR_EN
        exp_err = drop;
`else
        exp_err = 1'b0;
`endif
        if (e.lat > 0) chk("done_latency", 64'(cyc - e.hs), 64'(e.lat));
        chk("cfg_err", cfg_err, exp_err);
        if (!drop) begin
          if (e.dst) begin
            m_dst[e.rca][e.port]  = e.addr;
            m_dstw[e.rca][e.port] = 1'b1;
          end else begin
            m_src[e.rca][e.port]  = e.addr;
            m_srcw[e.rca][e.port] = 1'b1;
          end
        end
        rd_sel_mon = 2'(e.rca);
        mon_active = 1'b1;
        #1;
        chk("src_table", rca_src_reg_addrs, exp_src(e.rca));
        chk("dst_table", rca_dest_reg_addrs, exp_dst(e.rca));
        chk("configured", rca_configured, exp_cfgd());
        mon_active = 1'b0;
      end
    end else if (rst_n && cfg_err) begin
      chk("err_without_done", cfg_err, 0);
    end
  end

  task automatic do_cfg(input int rca, input int port, input bit dst, input int addr,
                        input int lat);
    int n = 0;
    @(negedge clk);
    cfg_valid    = 1'b1;
    cfg_rca_sel  = 2'(rca);
    cfg_port_sel = 3'(port);
    cfg_src_dest = dst;
    cfg_reg_addr = 5'(addr);
    while (!cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) chk("cfg_ready_timeout", 0, 1);
    else q.push_back('{rca: rca, port: port, dst: dst, addr: addr, hs: cyc, lat: lat});
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(q.size()), 0);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, cfg_ready, 1);
    chk({tag, "_stall"}, use_stall, 0);
    chk({tag, "_cfgd"}, rca_configured, 0);
    chk({tag, "_done"}, cfg_done, 0);
    chk({tag, "_err"}, cfg_err, 0);
    rd_sel_main = 2'd1;
    #1;
    chk({tag, "_src1"}, rca_src_reg_addrs, 0);
    chk({tag, "_dst1"}, rca_dest_reg_addrs, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("rst");

    // Basic source write, minimum latency.
    do_cfg(1, 2, 1'b0, 7, 3);
    wait_idle();

    // Config held in DRAIN until RCA0's two uses retire.
    use_issue = 1'b1; use_rca_sel = 2'd0;
    @(negedge clk);
    @(negedge clk);
    use_issue = 1'b0;
    do_cfg(0, 0, 1'b0, 5, 8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drain_stall0", use_stall[0], 1);
      chk("drain_ready", cfg_ready, 0);
    end
    @(negedge clk);
    use_complete = 1'b1; use_complete_rca_sel = 2'd0;
    @(negedge clk);
    @(negedge clk);
    use_complete = 1'b0;
    chk("drain_stall0_zero", use_stall[0], 1);
    wait_idle();

    // Saturation of RCA2's counter.
    use_rca_sel = 2'd2; use_complete_rca_sel = 2'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) chk("stall2_at3", use_stall[2], 0);
      use_issue = 1'b1;
    end
    @(negedge clk);
    chk("stall2_at4", use_stall[2], 1);
    @(negedge clk);
    chk("stall2_5th", use_stall[2], 1);
    use_complete = 1'b1;
    @(negedge clk);
    chk("stall2_both", use_stall[2], 1);
    use_issue = 1'b0;
    @(negedge clk);
    chk("stall2_at3_again", use_stall[2], 0);
    repeat (4) @(negedge clk);
    use_complete = 1'b0;
    do_cfg(2, 0, 1'b0, 9, 3);
    wait_idle();

    // Dropped writes: destination port out of range, RCA out of range.
    do_cfg(0, 3, 1'b1, 21, 3);
    wait_idle();
    do_cfg(3, 0, 1'b0, 11, 3);
    wait_idle();

    // Fill every port of RCA1.
    for (int p = 0; p < 5; p++) do_cfg(1, p, 1'b0, 10 + p, 3);
    for (int p = 0; p < 2; p++) do_cfg(1, p, 1'b1, 20 + p, 3);
    wait_idle();
    chk("configured_010", rca_configured, 3'b010);

    // Reset while a write is held in DRAIN.
    use_issue = 1'b1; use_rca_sel = 2'd1;
    @(negedge clk);
    use_issue = 1'b0;
    do_cfg(1, 0, 1'b0, 1, 0);
    @(negedge clk);
    chk("pre_rst_ready", cfg_ready, 0);
    chk("pre_rst_stall1", use_stall[1], 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    clear_model();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_done", cfg_done, 0);
    end
    check_reset_state("mid_rst");
    do_cfg(1, 4, 1'b0, 2, 3);
    wait_idle();

    chk("sb_empty", 64'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
